// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, zero/NOP words, stall bit position
// and the fetch FSM state constants.
package if_stage_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t ZeroWord = 32'h0000_0000;
    localparam inst_t      NopInst  = 32'h0000_0000;

    localparam int unsigned STALL_IF = 0;

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_MEM = 1'b1;

endpackage

// File: rtl/if_stage_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: async lookup, sync fill,
// sync valid clear on reset.
module icache_dm
    import if_stage_pkg::*;
#(
    parameter int unsigned CACHE_LINES = 256
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [$clog2(CACHE_LINES)-1:0]                rd_index,
    input  logic [INST_ADDR_W-$clog2(CACHE_LINES)-3:0]    rd_tag,
    output logic                                          hit,
    output inst_t                                         rd_data,
    input  logic                                          we,
    input  inst_addr_t                                    wr_addr,
    input  inst_t                                         wr_data
);

    localparam int unsigned IW = $clog2(CACHE_LINES);
    localparam int unsigned TW = INST_ADDR_W - IW - 2;

    logic [CACHE_LINES-1:0] valid;
    logic [TW-1:0]          tag_arr  [CACHE_LINES];
    inst_t                  data_arr [CACHE_LINES];

    logic [IW-1:0] wr_index;
    logic [TW-1:0] wr_tag;
    logic          unused_wr_bits;

    assign wr_index       = wr_addr[IW+1:2];
    assign wr_tag         = wr_addr[INST_ADDR_W-1:IW+2];
    assign unused_wr_bits = ^wr_addr[1:0];

    assign hit     = valid[rd_index] && (tag_arr[rd_index] == rd_tag);
    assign rd_data = data_arr[rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only read through its valid bit.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_arr[wr_index]  <= wr_tag;
            data_arr[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect handling and miss refill
// through a level request/ready handshake with the memory controller.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned CACHE_LINES = 256,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_enable,
    input  logic [31:0] branch_target,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);

    localparam int unsigned IW = $clog2(CACHE_LINES);

    logic [0:0]  state;
    inst_addr_t  pc;
    inst_addr_t  req_addr;
    inst_addr_t  redirect_pc;
    logic        hit;
    inst_t       line_data;
    logic        fill_we;
    logic        unused_inputs;

    assign redirect_pc   = {branch_target[31:2], 2'b00};
    assign fill_we       = (state == S_WAIT_MEM) && mem_ready;
    assign unused_inputs = ^{stall[5:1], branch_target[1:0]};

    icache_dm #(
        .CACHE_LINES(CACHE_LINES)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_index (pc[IW+1:2]),
        .rd_tag   (pc[INST_ADDR_W-1:IW+2]),
        .hit      (hit),
        .rd_data  (line_data),
        .we       (fill_we),
        .wr_addr  (req_addr),
        .wr_data  (mem_data)
    );

    always_comb begin
        if_pc       = ZeroWord;
        if_inst     = NopInst;
        stallreq_if = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = ZeroWord;
        if (!rst) begin
            if (state == S_IDLE) begin
                if (hit) begin
                    if_pc   = pc;
                    if_inst = line_data;
                end else begin
                    stallreq_if = 1'b1;
                end
            end else begin
                stallreq_if = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = req_addr;
            end
        end
    end

    // A redirect during a refill moves the PC at once; the refill still
    // completes into the line of req_addr before the new PC is looked up.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= {RESET_PC[31:2], 2'b00};
            state    <= S_IDLE;
            req_addr <= ZeroWord;
        end else begin
            case (state)
                S_IDLE: begin
                    if (branch_enable) begin
                        pc <= redirect_pc;
                    end else if (hit) begin
                        if (!stall[STALL_IF]) begin
                            pc <= pc + 32'd4;
                        end
                    end else begin
                        req_addr <= pc;
                        state    <= S_WAIT_MEM;
                    end
                end
                default: begin
                    if (branch_enable) begin
                        pc <= redirect_pc;
                    end
                    if (mem_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    a_no_stall_with_inst: assert property (@(posedge clk) disable iff (rst)
        !(stallreq_if && (if_inst != '0)));

    a_no_req_in_idle: assert property (@(posedge clk) disable iff (rst)
        !((state == S_IDLE) && mem_req));

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage against a cache model that stores
// whole line addresses in associative arrays.
module tb_if_stage;

    localparam int unsigned LINES = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        branch_enable = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data = '0;

    always #5 clk = ~clk;

    if_stage #(
        .CACHE_LINES(LINES),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_enable (branch_enable),
        .branch_target (branch_target),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .stallreq_if   (stallreq_if),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data)
    );

    typedef struct { bit stallreq; bit req; logic [31:0] addr; } ctrl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } fetch_t;

    ctrl_t  ctrl_q[$];
    fetch_t fetch_q[$];

    int checks = 0;
    int passes = 0;

    // Reference model: each line remembers the full word address it holds.
    logic [31:0] line_addr [int unsigned];
    logic [31:0] line_data [int unsigned];
    logic [31:0] m_pc = 32'h0;
    bit          m_wait = 0;
    logic [31:0] m_req = 32'h0;
    int unsigned m_wcnt = 0;
    int unsigned m_lat = 3;
    bit          rand_lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : ((a * 32'h9E37_79B1) | 32'h1);
    endfunction

    function automatic bit model_hit();
        int unsigned idx = (m_pc >> 2) % LINES;
        return !m_wait && line_addr.exists(idx) && (line_addr[idx] == m_pc);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit r, input bit s0, input bit br,
                        input logic [31:0] tgt, input bit spur);
        bit          hit;
        bit          rdy;
        int unsigned idx;
        ctrl_t       c;
        @(negedge clk);
        rdy = (!r && m_wait && (m_wcnt == m_lat)) || (spur && !m_wait);
        rst           = r;
        stall         = {5'($urandom_range(0, 31)), s0};
        branch_enable = br;
        branch_target = tgt;
        mem_ready     = rdy;
        mem_data      = (rdy && m_wait) ? mem_word(m_req) : $urandom;
        hit = model_hit();
        idx = (m_pc >> 2) % LINES;
        if (r)           c = '{0, 0, 32'h0};
        else if (m_wait) c = '{1, 1, m_req};
        else             c = '{!hit, 0, 32'h0};
        ctrl_q.push_back(c);
        if (!r && hit) fetch_q.push_back('{m_pc, line_data[idx]});
        if (r) begin
            m_pc = 32'h0; m_wait = 0; m_req = 32'h0;
            line_addr.delete(); line_data.delete();
        end else if (!m_wait) begin
            if (br)       m_pc = tgt & ~32'h3;
            else if (hit) begin if (!s0) m_pc = m_pc + 32'd4; end
            else begin
                m_wait = 1; m_req = m_pc; m_wcnt = 0;
                m_lat = rand_lat ? $urandom_range(0, 4) : 3;
            end
        end else begin
            if (br) m_pc = tgt & ~32'h3;
            if (rdy) begin
                line_addr[(m_req >> 2) % LINES] = m_req;
                line_data[(m_req >> 2) % LINES] = mem_data;
                m_wait = 0;
            end
            m_wcnt++;
        end
    endtask

    task automatic run_until_hit(input string name, input int bound);
        bit got = 0;
        for (int n = 0; n < bound && !got; n++) begin
            got = model_hit();
            step(0, 0, 0, 32'h0, 0);
        end
        if (!got) begin
            checks++;
            $display("FAIL %s_timeout: no hit within %0d cycles, required a hit", name, bound);
        end
    endtask

    // Monitor: control outputs every cycle; an instruction is popped whenever
    // the DUT presents one (stall request low outside reset).
    initial begin
        ctrl_t  c;
        fetch_t f;
        forever begin
            @(negedge clk);
            #2;
            if (ctrl_q.size() == 0) continue;
            c = ctrl_q.pop_front();
            check("stallreq_if", 32'(stallreq_if), 32'(c.stallreq));
            check("mem_req", 32'(mem_req), 32'(c.req));
            if (c.req) check("mem_addr", mem_addr, c.addr);
            if (!stallreq_if && !rst) begin
                if (fetch_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_fetch: got pc %h inst %h, required no instruction",
                             if_pc, if_inst);
                end else begin
                    f = fetch_q.pop_front();
                    check("if_pc", if_pc, f.pc);
                    check("if_inst", if_inst, f.inst);
                end
            end else begin
                check("if_pc_zero", if_pc, 32'h0);
                check("if_inst_zero", if_inst, 32'h0);
            end
        end
    end

    initial begin
        int          loops;
        bit          r, s0, br, sp;
        logic [31:0] t;

        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);

        // Cold start then two passes over 0x0..0xC.
        loops = 0;
        for (int n = 0; n < 200 && loops < 2; n++) begin
            br = model_hit() && (m_pc == 32'hC);
            if (br) loops++;
            step(0, 0, br, 32'h0, 0);
        end
        if (loops < 2) begin
            checks++;
            $display("FAIL loop_timeout: got %0d passes, required 2", loops);
        end

        // Stall hold on a hit at 0x8.
        step(0, 0, 1, 32'h8, 0);
        for (int n = 0; n < 3; n++) step(0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);

        // Redirect to 0x100 while refilling 0x10; 0x10 must hit later.
        step(0, 0, 1, 32'h10, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h101, 0);
        run_until_hit("redirect", 30);
        step(0, 0, 1, 32'h10, 0);
        run_until_hit("refill_hit", 30);

        // Aliasing 0x0 / 0x400.
        step(0, 0, 1, 32'h400, 0);
        run_until_hit("alias_a", 30);
        step(0, 0, 1, 32'h0, 0);
        run_until_hit("alias_b", 30);

        // PC wrap past 0xFFFFFFFC.
        step(0, 0, 1, 32'hFFFF_FFF8, 0);
        run_until_hit("wrap_a", 30);
        run_until_hit("wrap_b", 30);
        run_until_hit("wrap_c", 30);

        // Reset in the middle of a refill, late ready one cycle after reset.
        step(0, 0, 1, 32'h200, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        run_until_hit("post_reset", 30);

        rand_lat = 1;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            s0 = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           t = $urandom & 32'h0000_07FF;
            step(r, s0, br, t, sp);
        end

        repeat (2) @(negedge clk);
        #5;
        check("fetch_queue_drained", fetch_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Holds the PC and serves instructions from a small direct-mapped instruction cache.
- On a miss, fetches a word from the memory controller through a level handshake and raises a stall request to the stall controller.
- Redirects the PC on a taken branch or jump signalled by EX.

Parameters:
- CACHE_LINES, 256, number of one-word cache lines; power of two, at least 2.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall  in  6  pipeline stall vector; bit 0 freezes the PC
- branch_enable  in  1  taken branch or jump redirect from EX
- branch_target  in  32  redirect address
- if_pc  out  32  PC of the instruction presented to IF/ID
- if_inst  out  32  instruction presented to IF/ID
- stallreq_if  out  1  stall request to the stall controller
- mem_req  out  1  fetch request to the memory controller
- mem_addr  out  32  word address of the fetch
- mem_ready  in  1  one-cycle pulse: fetched word valid
- mem_data  in  32  fetched word

Behaviour:
Reset (rst=1 at clk edge):
- pc <= RESET_PC; all cache valid bits cleared; state <= IDLE; req_addr <= 0.
- While rst=1, all outputs are 0.

Address split:
- index = pc[2+IW-1:2], where IW = log2(CACHE_LINES).
- tag = pc[31:2+IW].
- pc[1:0] is always 0; branch_target[1:0] is ignored (forced to 0 when loaded).

State IDLE, combinational outputs:
- hit = valid[index] && tag_arr[index] == tag.
- On hit: if_pc = pc, if_inst = data_arr[index], stallreq_if = 0, mem_req = 0.
- On miss: if_pc = 0, if_inst = 0, stallreq_if = 1, mem_req = 0. The request is issued from WAIT_MEM next cycle.

State IDLE, sequential:
- branch_enable=1: pc <= branch_target; stay IDLE. Branch wins over stall[0] and over a miss; no fetch is issued for the old PC.
- Otherwise, hit and stall[0]=0: pc <= pc+4 (32-bit wrap, 0xFFFFFFFC to 0).
- Otherwise, hit and stall[0]=1: pc holds.
- Otherwise, miss: req_addr <= pc; state <= WAIT_MEM.

State WAIT_MEM:
- mem_req = 1 and mem_addr = req_addr, held stable until mem_ready.
- if_pc = 0, if_inst = 0, stallreq_if = 1.
- mem_ready=1: write data/tag/valid at the index and tag of req_addr; state <= IDLE. The next cycle hits if pc still equals req_addr, so miss latency is memory latency + 2 cycles.
- branch_enable=1 in WAIT_MEM: pc <= branch_target immediately. The outstanding request is not aborted; it completes and still fills the cache at req_addr. Only then does the state return to IDLE and look up the new pc.
- Branch and mem_ready in the same cycle: both take effect.
- rst in WAIT_MEM: abandon the request, mem_req drops next cycle. A late mem_ready after reset is ignored (it is ignored in IDLE).

Invariants:
- stallreq_if is never 1 on the same cycle as valid (nonzero) if_inst.
- mem_req is never asserted in IDLE.

Decomposition:
- Shared defines file: ZeroWord, InstAddrBus and InstBus widths, NOP encoding, stall-bit index for IF.
- Sub-module icache_dm holds the valid/tag/data arrays:
  - async read port (index, tag) giving hit and data;
  - sync write port (we, addr, data);
  - sync valid clear on rst.
- The FSM and PC logic stay in if_stage.

Test Plan:
- Cold start with rst pulse, mem latency 3, mem_data 0x00000013 -> stallreq_if=1 for 5 cycles, mem_addr=0; then if_pc=0, if_inst=0x13, stallreq_if=0; next PC 4 misses.
- Loop over 0x0..0xC twice, second pass -> zero stallreq_if cycles; mem_req never asserted.
- stall[0]=1 held 3 cycles on a hit at pc=0x8 -> if_pc stays 0x8, if_inst stable, pc does not advance.
- branch_enable with target 0x100 during WAIT_MEM for 0x10 -> fill at 0x10 completes and 0x10 later hits; pc=0x100 is fetched next; stallreq_if=1 throughout.
- Aliasing: 0x0 and 0x400 with CACHE_LINES=256 -> 0x400 evicts 0x0; refetch of 0x0 misses again with the correct data.
- rst asserted mid-WAIT_MEM, with mem_ready arriving 1 cycle after reset -> no cache write, valid bits all 0, pc=0.
